// File: rtl/line_mem_responder.sv
// Memory-side responder for the per-line controller: word-addressed line store
// with a shared word pointer, registered reads, write-completion pulse and line zero-fill.
module line_mem_responder #(
  parameter int SIZE    = 25,
  parameter int MEMSIZE = 3,
  parameter int WORDS   = 5,
  parameter int PTRW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               write,
  input  logic               initLine,
  input  logic [MEMSIZE-1:0] line,
  input  logic [SIZE-1:0]    writeVal,
  output logic [SIZE-1:0]    readVal,
  output logic               rvalid,
  output logic               done,
  output logic               busy,
  output logic [PTRW-1:0]    ptr
);

  // Each line occupies a power-of-two slot so the address is a plain concatenation.
  localparam int AW    = MEMSIZE + PTRW;
  localparam int DEPTH = 1 << AW;
  localparam logic [PTRW-1:0] LAST = PTRW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CLEAR
  } state_t;

  logic [SIZE-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [PTRW-1:0]    ptr_q, ptr_d;
  logic [MEMSIZE-1:0] clr_line_q, clr_line_d;
  logic [PTRW-1:0]    clr_idx_q, clr_idx_d;
  logic               rvalid_q, rvalid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [SIZE-1:0]    readVal_q;

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [SIZE-1:0]    mem_wdata;
  logic               mem_re;
  logic [AW-1:0]      acc_addr;

  assign acc_addr = {line, ptr_q};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_line_d = clr_line_q;
    clr_idx_d  = clr_idx_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = acc_addr;
    mem_wdata  = writeVal;
    mem_re     = 1'b0;

    case (state_q)
      IDLE, ACCESS: begin
        if (initLine) begin
          // initLine wins; any read/write in the same cycle is dropped.
          state_d    = CLEAR;
          clr_line_d = line;
          clr_idx_d  = '0;
          ptr_d      = '0;
          busy_d     = 1'b1;
        end else if (read || write) begin
          state_d = ACCESS;
          if (read) begin
            mem_re   = 1'b1;
            rvalid_d = 1'b1;
          end
          if (write) begin
            mem_we = 1'b1;
            if (ptr_q == LAST) begin
              ptr_d  = '0;
              done_d = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = {clr_line_q, clr_idx_q};
        mem_wdata = '0;
        if (clr_idx_q == LAST) begin
          state_d   = IDLE;
          clr_idx_d = '0;
          ptr_d     = '0;
          busy_d    = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_line_q <= '0;
      clr_idx_q  <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_line_q <= clr_line_d;
      clr_idx_q  <= clr_idx_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Store has no reset; only a zero-fill clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Reading and writing the same word on one edge returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readVal_q <= '0;
    end else if (mem_re) begin
      readVal_q <= mem[acc_addr];
    end
  end

  assign readVal = readVal_q;
  assign rvalid  = rvalid_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed scenarios plus randomized
// traffic compared against a transaction-level model of the line store.
module tb_line_mem_responder;

  localparam int SIZE    = 25;
  localparam int MEMSIZE = 3;
  localparam int WORDS   = 5;
  localparam int PTRW    = 3;
  localparam int LINES   = 1 << MEMSIZE;

  logic               clk = 1'b0;
  logic               rst;
  logic               read;
  logic               write;
  logic               initLine;
  logic [MEMSIZE-1:0] line;
  logic [SIZE-1:0]    writeVal;
  logic [SIZE-1:0]    readVal;
  logic               rvalid;
  logic               done;
  logic               busy;
  logic [PTRW-1:0]    ptr;

  int checks = 0;
  int errors = 0;

  line_mem_responder #(
    .SIZE(SIZE), .MEMSIZE(MEMSIZE), .WORDS(WORDS), .PTRW(PTRW)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .initLine(initLine),
    .line(line), .writeVal(writeVal), .readVal(readVal), .rvalid(rvalid),
    .done(done), .busy(busy), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Reference model: the store as a 2-D array, a word pointer and a count of
  // words still to be zeroed.
  logic [SIZE-1:0] m_mem   [LINES][WORDS];
  bit              m_known [LINES][WORDS];
  int              m_ptr;
  int              m_clr_left;
  int              m_clr_line;
  logic [SIZE-1:0] e_rd;
  bit              e_rd_known;
  bit              e_rvalid;
  bit              e_done;
  bit              e_busy;

  task automatic model_reset();
    m_ptr      = 0;
    m_clr_left = 0;
    e_rd       = '0;
    e_rd_known = 1'b1;
    e_rvalid   = 1'b0;
    e_done     = 1'b0;
    e_busy     = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit w, input bit il,
                            input int ln, input logic [SIZE-1:0] v);
    e_rvalid = 1'b0;
    e_done   = 1'b0;
    if (m_clr_left > 0) begin
      m_mem[m_clr_line][WORDS - m_clr_left]   = '0;
      m_known[m_clr_line][WORDS - m_clr_left] = 1'b1;
      m_clr_left--;
    end else if (il) begin
      m_clr_left = WORDS;
      m_clr_line = ln;
      m_ptr      = 0;
    end else begin
      if (r) begin
        e_rd       = m_mem[ln][m_ptr];
        e_rd_known = m_known[ln][m_ptr];
        e_rvalid   = 1'b1;
      end
      if (w) begin
        m_mem[ln][m_ptr]   = v;
        m_known[ln][m_ptr] = 1'b1;
        e_done             = (m_ptr == WORDS - 1);
        m_ptr              = (m_ptr + 1) % WORDS;
      end
    end
    e_busy = (m_clr_left > 0);
  endtask

  // One clock: present strobes, take the edge, update the model, then sample at edge+1.
  task automatic step(input bit r, input bit w, input bit il,
                      input int ln, input logic [SIZE-1:0] v);
    read     = r;
    write    = w;
    initLine = il;
    line     = MEMSIZE'(ln);
    writeVal = v;
    @(posedge clk);
    model_edge(r, w, il, ln, v);
    #1;
    read     = 1'b0;
    write    = 1'b0;
    initLine = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; read = 1'b0; write = 1'b0; initLine = 1'b0;
    line = '0; writeVal = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (readVal !== '0) begin errors++; $display("FAIL reset_readVal: got %0h expected 0", readVal); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("reset released: ptr=%0d busy=%b", ptr, busy);
  endtask

  task automatic test_read_latency();
    logic [SIZE-1:0] pre [WORDS];
    for (int k = 0; k < WORDS; k++) begin
      pre[k] = SIZE'($urandom);
      step(1'b0, 1'b1, 1'b0, 2, pre[k]);
    end
    step(1'b1, 1'b0, 1'b0, 2, '0);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid: got %b expected 1", rvalid); end
    checks++; if (readVal !== pre[0]) begin errors++; $display("FAIL read_data: got %0h expected %0h", readVal, pre[0]); end
    checks++; if (ptr !== '0) begin errors++; $display("FAIL read_ptr: got %0d expected 0", ptr); end
    $display("read [2][0]: readVal=%0h rvalid=%b ptr=%0d", readVal, rvalid, ptr);
    step(1'b0, 1'b0, 1'b0, 2, '0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL read_rvalid_pulse: got %b expected 0", rvalid); end
  endtask

  task automatic test_write_seq();
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, 1'b1, 1'b0, 1, SIZE'(10 + i));
      checks++; if (ptr !== PTRW'((i + 1) % WORDS)) begin errors++; $display("FAIL wseq_ptr%0d: got %0d expected %0d", i, ptr, (i + 1) % WORDS); end
      checks++; if (done !== (i == WORDS - 1)) begin errors++; $display("FAIL wseq_done%0d: got %b expected %b", i, done, (i == WORDS - 1)); end
      $display("write [1] val=%0d: ptr=%0d done=%b", 10 + i, ptr, done);
    end
    step(1'b0, 1'b0, 1'b0, 1, '0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wseq_done_pulse: got %b expected 0", done); end
    // Read back by rewriting the same values, so ptr walks the line without altering it.
    for (int k = 0; k < WORDS; k++) begin
      step(1'b1, 1'b1, 1'b0, 1, SIZE'(10 + k));
      checks++; if (readVal !== SIZE'(10 + k) || rvalid !== 1'b1) begin errors++; $display("FAIL wseq_readback%0d: got %0d/%b expected %0d/1", k, readVal, rvalid, 10 + k); end
      $display("readback [1][%0d]=%0d", k, readVal);
    end
  endtask

  task automatic test_read_write_same();
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(10));
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(11));
    step(1'b1, 1'b1, 1'b0, 1, SIZE'(99));
    checks++; if (readVal !== SIZE'(12)) begin errors++; $display("FAIL rw_old_data: got %0d expected 12", readVal); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rw_rvalid: got %b expected 1", rvalid); end
    checks++; if (ptr !== PTRW'(3)) begin errors++; $display("FAIL rw_ptr: got %0d expected 3", ptr); end
    $display("read+write [1][2]: readVal=%0d ptr=%0d", readVal, ptr);
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(13));
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(14));
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(10));
    step(1'b0, 1'b1, 1'b0, 1, SIZE'(11));
    step(1'b1, 1'b0, 1'b0, 1, '0);
    checks++; if (readVal !== SIZE'(99)) begin errors++; $display("FAIL rw_new_data: got %0d expected 99", readVal); end
    $display("read [1][2] after write: readVal=%0d", readVal);
  endtask

  task automatic test_init_line();
    step(1'b0, 1'b0, 1'b1, 1, '0);
    checks++; if (busy !== 1'b1 || ptr !== '0) begin errors++; $display("FAIL init_entry: got busy=%b ptr=%0d expected busy=1 ptr=0", busy, ptr); end
    for (int i = 0; i < WORDS; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0, 1, SIZE'($urandom));
      checks++; if (busy !== (i < WORDS - 1)) begin errors++; $display("FAIL init_busy%0d: got %b expected %b", i, busy, (i < WORDS - 1)); end
      checks++; if (rvalid !== 1'b0 || done !== 1'b0 || ptr !== '0) begin errors++; $display("FAIL init_ignore%0d: got rvalid=%b done=%b ptr=%0d expected 0/0/0", i, rvalid, done, ptr); end
      $display("clear cycle %0d: busy=%b ptr=%0d", i, busy, ptr);
    end
    for (int k = 0; k < WORDS; k++) begin
      step(1'b1, 1'b1, 1'b0, 1, SIZE'($urandom));
      checks++; if (readVal !== '0 || rvalid !== 1'b1) begin errors++; $display("FAIL init_zero%0d: got %0h/%b expected 0/1", k, readVal, rvalid); end
    end
  endtask

  task automatic test_init_with_write();
    step(1'b0, 1'b1, 1'b0, 3, SIZE'($urandom));
    step(1'b0, 1'b1, 1'b1, 3, SIZE'($urandom));
    checks++; if (busy !== 1'b1 || done !== 1'b0 || ptr !== '0) begin errors++; $display("FAIL initw_entry: got busy=%b done=%b ptr=%0d expected 1/0/0", busy, done, ptr); end
    $display("initLine+write: busy=%b ptr=%0d", busy, ptr);
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, 1'b0, 1'b0, 3, '0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL initw_done%0d: got %b expected 0", i, done); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL initw_exit: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_clear();
    logic [SIZE-1:0] pre [WORDS];
    logic [SIZE-1:0] want;
    for (int k = 0; k < WORDS; k++) begin
      pre[k] = SIZE'($urandom);
      step(1'b0, 1'b1, 1'b0, 4, pre[k]);
    end
    step(1'b0, 1'b0, 1'b1, 4, '0);
    step(1'b0, 1'b0, 1'b0, 4, '0);
    step(1'b0, 1'b0, 1'b0, 4, '0);
    // Now inside the third clear cycle; reset before the next edge.
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ptr !== '0) begin errors++; $display("FAIL rstclr_abort: got busy=%b ptr=%0d expected 0/0", busy, ptr); end
    $display("reset mid-clear: busy=%b ptr=%0d", busy, ptr);
    model_reset();
    #1 rst = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      want = (k < 2) ? '0 : pre[k];
      step(1'b1, 1'b1, 1'b0, 4, want);
      checks++; if (readVal !== want) begin errors++; $display("FAIL rstclr_word%0d: got %0h expected %0h", k, readVal, want); end
      checks++; if (done !== (k == WORDS - 1)) begin errors++; $display("FAIL rstclr_done%0d: got %b expected %b", k, done, (k == WORDS - 1)); end
      $display("partial line [4][%0d]=%0h", k, readVal);
    end
  endtask

  task automatic test_random();
    bit r, w, il;
    int ln;
    for (int l = 0; l < LINES; l++) begin
      step(1'b0, 1'b0, 1'b1, l, '0);
      repeat (WORDS) step(1'b0, 1'b0, 1'b0, l, '0);
    end
    for (int n = 0; n < 400; n++) begin
      il = ($urandom_range(0, 19) == 0);
      r  = 1'($urandom);
      w  = 1'($urandom);
      ln = $urandom_range(0, LINES - 1);
      step(r, w, il, ln, SIZE'($urandom));
      checks++; if (rvalid !== e_rvalid) begin errors++; $display("FAIL rand_rvalid%0d: got %b expected %b", n, rvalid, e_rvalid); end
      checks++; if (done !== e_done) begin errors++; $display("FAIL rand_done%0d: got %b expected %b", n, done, e_done); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy%0d: got %b expected %b", n, busy, e_busy); end
      checks++; if (ptr !== PTRW'(m_ptr)) begin errors++; $display("FAIL rand_ptr%0d: got %0d expected %0d", n, ptr, m_ptr); end
      if (e_rd_known) begin
        checks++; if (readVal !== e_rd) begin errors++; $display("FAIL rand_readVal%0d: got %0h expected %0h", n, readVal, e_rd); end
      end
      $display("rand %0d: r=%b w=%b il=%b line=%0d -> readVal=%0h rvalid=%b done=%b busy=%b ptr=%0d",
               n, r, w, il, ln, readVal, rvalid, done, busy, ptr);
    end
  endtask

  initial begin
    for (int l = 0; l < LINES; l++) begin
      for (int k = 0; k < WORDS; k++) begin
        m_mem[l][k]   = '0;
        m_known[l][k] = 1'b0;
      end
    end
    m_clr_line = 0;
    model_reset();
    test_reset();
    test_read_latency();
    test_write_seq();
    test_read_write_same();
    test_init_line();
    test_init_with_write();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
